// File: rtl/f1_pkg.sv
// Shared types and constants for the f1 self-test sequencer.
//   state_e   : sequencer states
//   VEC_W     : width of the {a,b,c,d} input vector
//   F1_TRUTH  : golden truth table, bit i = f1(i)
//   SETTLE_W  : width of the settle-cycle down-counter
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int unsigned  VEC_W    = 4;
    localparam logic [15:0]  F1_TRUTH = 16'hE2CE;
    localparam int unsigned  SETTLE_W = 8;

endpackage

// File: rtl/f1_golden_cmp.sv
// Combinational golden-model comparator for f1.
//   idx        : current vector {a,b,c,d}
//   o_and_or   : and-or implementation output
//   o_nand     : nand-only implementation output
//   o_nor      : nor-only implementation output
//   mis_*      : 1 when the matching implementation disagrees with f1(idx)
module f1_golden_cmp
    import f1_pkg::*;
(
    input  logic [VEC_W-1:0] idx,
    input  logic             o_and_or,
    input  logic             o_nand,
    input  logic             o_nor,
    output logic             mis_and_or,
    output logic             mis_nand,
    output logic             mis_nor
);

    logic golden;

    // 4-state inequality so an X/Z from an implementation reads as a failure.
    always_comb begin
        golden     = F1_TRUTH[idx];
        mis_and_or = (o_and_or !== golden);
        mis_nand   = (o_nand   !== golden);
        mis_nor    = (o_nor    !== golden);
    end

endmodule

// File: rtl/f1_sweep_ctrl.sv
// Self-test sequencer for the three f1 gate-level implementations.
// Sweeps {a,b,c,d} through all 16 vectors, holds each for SETTLE_CYCLES,
// samples on the following cycle and accumulates error results.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start, abort        : begin sweep (IDLE only) / cancel sweep
//   o_and_or/nand/nor   : outputs of the implementations under test
//   a, b, c, d          : driven vector, a is the MSB
//   busy, done          : sweep running / one-cycle completion pulse
//   pass                : last completed sweep had no mismatches
//   err_*               : sticky per-implementation error flags
//   mismatch_cnt        : saturating count of failing vectors
//   first_fail_vec/valid: index of the first failing vector
module f1_sweep_ctrl
    import f1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             o_and_or,
    input  logic             o_nand,
    input  logic             o_nor,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_and_or,
    output logic             err_nand,
    output logic             err_nor,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
    // With no settle time each vector goes straight to its sample cycle.
    localparam state_e VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e              state_q;
    logic [VEC_W-1:0]    vec_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                mis_and_or;
    logic                mis_nand;
    logic                mis_nor;
    logic                any_mis;

    assign {a, b, c, d} = vec_q;
    assign any_mis      = mis_and_or | mis_nand | mis_nor;

    f1_golden_cmp u_cmp (
        .idx        (vec_q),
        .o_and_or   (o_and_or),
        .o_nand     (o_nand),
        .o_nor      (o_nor),
        .mis_and_or (mis_and_or),
        .mis_nand   (mis_nand),
        .mis_nor    (mis_nor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            vec_q            <= '0;
            settle_cnt_q     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_and_or       <= 1'b0;
            err_nand         <= 1'b0;
            err_nor          <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        vec_q            <= '0;
                        settle_cnt_q     <= SETTLE_INIT;
                        err_and_or       <= 1'b0;
                        err_nand         <= 1'b0;
                        err_nor          <= 1'b0;
                        mismatch_cnt     <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                        state_q          <= VEC_ENTRY;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                        if (settle_cnt_q <= SETTLE_W'(1)) begin
                            state_q <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (mis_and_or) err_and_or <= 1'b1;
                        if (mis_nand)   err_nand   <= 1'b1;
                        if (mis_nor)    err_nor    <= 1'b1;
                        // At most one count per vector, however many implementations fail.
                        if (any_mis) begin
                            if (mismatch_cnt != CNT_MAX) begin
                                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                            end
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec_q;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (vec_q == '1) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            vec_q        <= vec_q + VEC_W'(1);
                            settle_cnt_q <= SETTLE_INIT;
                            state_q      <= VEC_ENTRY;
                        end
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    // The count saturates rather than wraps, so zero means no failures.
                    pass    <= (mismatch_cnt == '0);
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f1_sweep_ctrl.sv
// Directed bench for f1_sweep_ctrl: a default instance (SETTLE_CYCLES=2, CNT_W=5)
// and a fast instance (SETTLE_CYCLES=0, CNT_W=3). Implementation outputs are the
// golden f1 value XOR a per-vector fault mask.
module tb_f1_sweep_ctrl;

    localparam logic [15:0] TRUTH = 16'hE2CE;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, start0;

    logic [15:0] flip_and_or, flip_nand, flip_nor;

    // default instance
    logic       o_and_or, o_nand, o_nor;
    logic       a, b, c, d, busy, done, pass, err_and_or, err_nand, err_nor;
    logic [4:0] mismatch_cnt;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;
    logic [3:0] vec;

    // fast instance
    logic       o_and_or0, o_nand0, o_nor0;
    logic       a0, b0, c0, d0, busy0, done0, pass0, err_and_or0, err_nand0, err_nor0;
    logic [2:0] mismatch_cnt0;
    logic [3:0] first_fail_vec0;
    logic       first_fail_valid0;
    logic [3:0] vec0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign vec       = {a, b, c, d};
    assign o_and_or  = TRUTH[vec] ^ flip_and_or[vec];
    assign o_nand    = TRUTH[vec] ^ flip_nand[vec];
    assign o_nor     = TRUTH[vec] ^ flip_nor[vec];

    // fast instance: and-or always wrong, the others correct
    assign vec0      = {a0, b0, c0, d0};
    assign o_and_or0 = ~TRUTH[vec0];
    assign o_nand0   = TRUTH[vec0];
    assign o_nor0    = TRUTH[vec0];

    f1_sweep_ctrl #(
        .SETTLE_CYCLES (2),
        .CNT_W         (5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .o_and_or         (o_and_or),
        .o_nand           (o_nand),
        .o_nor            (o_nor),
        .a                (a),
        .b                (b),
        .c                (c),
        .d                (d),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_and_or       (err_and_or),
        .err_nand         (err_nand),
        .err_nor          (err_nor),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    f1_sweep_ctrl #(
        .SETTLE_CYCLES (0),
        .CNT_W         (3)
    ) dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start0),
        .abort            (1'b0),
        .o_and_or         (o_and_or0),
        .o_nand           (o_nand0),
        .o_nor            (o_nor0),
        .a                (a0),
        .b                (b0),
        .c                (c0),
        .d                (d0),
        .busy             (busy0),
        .done             (done0),
        .pass             (pass0),
        .err_and_or       (err_and_or0),
        .err_nand         (err_nand0),
        .err_nor          (err_nor0),
        .mismatch_cnt     (mismatch_cnt0),
        .first_fail_vec   (first_fail_vec0),
        .first_fail_valid (first_fail_valid0)
    );

    // Stimulus only: pulse start on the chosen instance and count edges until done.
    // done_at = number of edges after the start edge, or 999 on timeout.
    task automatic run_sweep(input bit which, output int done_at);
        int k;
        @(negedge clk);
        if (which) start0 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
        k = 0;
        while (!(which ? done0 : done) && k < 300) begin
            @(negedge clk);
            k++;
        end
        done_at = (k < 300) ? k : 999;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({a, b, c, d, busy, done, pass, err_and_or, err_nand, err_nor} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0",
                     {a, b, c, d, busy, done, pass, err_and_or, err_nand, err_nor});
        end
        n_cmp++;
        if ({mismatch_cnt, first_fail_vec, first_fail_valid} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_results: got %h want 0",
                     {mismatch_cnt, first_fail_vec, first_fail_valid});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_clean_sweep();
        int k;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            if (k < 48) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clean_busy k=%0d: got %b want 1", k, busy);
                end
                n_cmp++;
                if (vec !== 4'(k / 3)) begin
                    n_fail++;
                    $display("FAIL clean_vec k=%0d: got %0d want %0d", k, vec, k / 3);
                end
            end
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != 48) begin
            n_fail++;
            $display("FAIL clean_done_at: got %0d want 48", k);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_busy_done: got %b want 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_done_pulse: got %b want 0", done);
        end
        n_cmp++;
        if ({pass, err_and_or, err_nand, err_nor, mismatch_cnt, first_fail_valid} !== 10'b1000_00000_0) begin
            n_fail++;
            $display("FAIL clean_results: got pass=%b err=%b%b%b cnt=%0d ffv=%b want 1 000 0 0",
                     pass, err_and_or, err_nand, err_nor, mismatch_cnt, first_fail_valid);
        end
    endtask

    task automatic test_nor_stuck0();
        int t;
        flip_nor = TRUTH;  // stuck-at-0 differs wherever f1 is 1
        run_sweep(1'b0, t);
        @(negedge clk);
        flip_nor = 16'h0;
        n_cmp++;
        if (t != 48) begin
            n_fail++;
            $display("FAIL nor_done_at: got %0d want 48", t);
        end
        n_cmp++;
        if ({err_and_or, err_nand, err_nor} !== 3'b001) begin
            n_fail++;
            $display("FAIL nor_err: got %b%b%b want 001", err_and_or, err_nand, err_nor);
        end
        n_cmp++;
        if (mismatch_cnt !== 5'd9) begin
            n_fail++;
            $display("FAIL nor_cnt: got %0d want 9", mismatch_cnt);
        end
        n_cmp++;
        if (first_fail_valid !== 1'b1 || first_fail_vec !== 4'd1) begin
            n_fail++;
            $display("FAIL nor_first: got %b/%0d want 1/1", first_fail_valid, first_fail_vec);
        end
        n_cmp++;
        if (pass !== 1'b0) begin
            n_fail++;
            $display("FAIL nor_pass: got %b want 0", pass);
        end
    endtask

    task automatic test_nand_vec14();
        int t;
        flip_nand = 16'h4000;
        run_sweep(1'b0, t);
        @(negedge clk);
        flip_nand = 16'h0;
        n_cmp++;
        if (mismatch_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL nand_cnt: got %0d want 1", mismatch_cnt);
        end
        n_cmp++;
        if (first_fail_valid !== 1'b1 || first_fail_vec !== 4'd14) begin
            n_fail++;
            $display("FAIL nand_first: got %b/%0d want 1/14", first_fail_valid, first_fail_vec);
        end
        n_cmp++;
        if ({err_and_or, err_nand, err_nor} !== 3'b010) begin
            n_fail++;
            $display("FAIL nand_err: got %b%b%b want 010", err_and_or, err_nand, err_nor);
        end
        n_cmp++;
        if (pass !== 1'b0) begin
            n_fail++;
            $display("FAIL nand_pass: got %b want 0", pass);
        end
    endtask

    task automatic test_start_mid_sweep();
        int k;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            start = (k == 10 || k == 30);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_cmp++;
        if (k != 48) begin
            n_fail++;
            $display("FAIL midstart_done_at: got %0d want 48", k);
        end
        @(negedge clk);
        n_cmp++;
        if (pass !== 1'b1) begin
            n_fail++;
            $display("FAIL midstart_pass: got %b want 1", pass);
        end
    endtask

    task automatic test_abort();
        int t;
        bit seen_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
        end
        n_cmp++;
        if (vec !== 4'd6) begin
            n_fail++;
            $display("FAIL abort_vec_hold: got %0d want 6", vec);
        end
        seen_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got done_seen=%b busy=%b want 0 0", seen_done, busy);
        end
        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b want 0", busy);
        end
        run_sweep(1'b0, t);
        n_cmp++;
        if (t != 48) begin
            n_fail++;
            $display("FAIL abort_rerun_done_at: got %0d want 48", t);
        end
        @(negedge clk);
        n_cmp++;
        if (pass !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rerun_pass: got %b want 1", pass);
        end
    endtask

    task automatic test_saturate_fast();
        int t;
        run_sweep(1'b1, t);
        n_cmp++;
        if (t != 16) begin
            n_fail++;
            $display("FAIL fast_done_at: got %0d want 16", t);
        end
        n_cmp++;
        if (mismatch_cnt0 !== 3'd7) begin
            n_fail++;
            $display("FAIL fast_cnt_sat: got %0d want 7", mismatch_cnt0);
        end
        n_cmp++;
        if (first_fail_valid0 !== 1'b1 || first_fail_vec0 !== 4'd0) begin
            n_fail++;
            $display("FAIL fast_first: got %b/%0d want 1/0", first_fail_valid0, first_fail_vec0);
        end
        n_cmp++;
        if ({err_and_or0, err_nand0, err_nor0} !== 3'b100) begin
            n_fail++;
            $display("FAIL fast_err: got %b%b%b want 100", err_and_or0, err_nand0, err_nor0);
        end
        @(negedge clk);
        n_cmp++;
        if (pass0 !== 1'b0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_pass: got pass=%b done=%b want 0 0", pass0, done0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit seen_done;
        flip_nor = TRUTH;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        // vectors 0..5 sampled so far; f1 is 1 at 1, 2 and 3
        n_cmp++;
        if (mismatch_cnt !== 5'd3 || err_nor !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got cnt=%0d err_nor=%b want 3 1", mismatch_cnt, err_nor);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a, b, c, d, busy, done, pass, err_and_or, err_nand, err_nor,
             mismatch_cnt, first_fail_vec, first_fail_valid} !== 20'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got vec=%0d busy=%b err_nor=%b cnt=%0d ffv=%b want all 0",
                     vec, busy, err_nor, mismatch_cnt, first_fail_valid);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        rst_n    = 1'b1;
        flip_nor = 16'h0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got activity=%b want 0", seen_done);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start0      = 1'b0;
        abort       = 1'b0;
        flip_and_or = 16'h0;
        flip_nand   = 16'h0;
        flip_nor    = 16'h0;

        test_reset();
        test_clean_sweep();
        test_nor_stuck0();
        test_nand_vec14();
        test_start_mid_sweep();
        test_abort();
        test_saturate_fast();
        test_reset_mid_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
